// File: rtl/pulse_sched_pkg.sv
// Shared types and default timing constants for the pulse LED scheduler.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ON    = 2'd2
    } state_t;

    // One second at the 100 MHz system clock.
    localparam int unsigned DELAY_1S = 100_000_000;
    localparam int unsigned ON_1S    = 100_000_000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
module rr_arbiter #(
    parameter int unsigned N = 2,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    // First requester found after ptr, in circular order, wins.
    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = W'(idx);
            end
        end
    end

endmodule

// File: rtl/pulse_led_scheduler.sv
// Queues per-channel event strobes and plays them out one at a time on a
// shared LED: a delay window followed by an on window per event.
module pulse_led_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned PEND_W       = 8,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DELAY_CYCLES = DELAY_1S,
    parameter int unsigned ON_CYCLES    = ON_1S,
    localparam int unsigned CH_W        = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    output logic            led,
    output logic [CH_W-1:0] active_ch,
    output logic            busy,
    output logic [N_CH-1:0] overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [CNT_W-1:0]  DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ON_LAST    = CNT_W'(ON_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              led_d, busy_d;
    logic [CH_W-1:0]   active_d;
    logic [CH_W-1:0]   ptr_q;
    logic [PEND_W-1:0] pend_q [N_CH];
    logic [PEND_W-1:0] pend_d [N_CH];
    logic [N_CH-1:0]   ovf_d;
    logic [N_CH-1:0]   pend_nz;
    logic [N_CH-1:0]   grant_vec;
    logic              grant_en;
    logic              arb_valid;
    logic [CH_W-1:0]   arb_idx;

    // Channels with at least one queued event are eligible for arbitration.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pend_nz[i] = (pend_q[i] != '0);
        end
    end

    rr_arbiter #(
        .N (N_CH),
        .W (CH_W)
    ) u_arb (
        .req         (pend_nz),
        .ptr         (ptr_q),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    // Next-state and registered-output values for the serve sequence.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        led_d    = led;
        busy_d   = busy;
        active_d = active_ch;
        grant_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_en = 1'b1;
                    state_d  = DELAY;
                    timer_d  = '0;
                    active_d = arb_idx;
                    busy_d   = 1'b1;
                end
            end
            DELAY: begin
                if (timer_q == DELAY_LAST) begin
                    state_d = ON;
                    timer_d = '0;
                    led_d   = 1'b1;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ON: begin
                if (timer_q == ON_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    led_d   = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                led_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // One-hot view of the channel granted on this edge.
    always_comb begin
        grant_vec = '0;
        if (grant_en) begin
            grant_vec = N_CH'(1) << arb_idx;
        end
    end

    // Saturating pending counters; a strobe that cannot be counted is flagged.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pend_d[i] = pend_q[i];
            ovf_d[i]  = overflow[i];
            if (req[i] && !grant_vec[i]) begin
                if (pend_q[i] == PEND_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + PEND_W'(1);
                end
            end else if (!req[i] && grant_vec[i]) begin
                pend_d[i] = pend_q[i] - PEND_W'(1);
            end
        end
    end

    // State, timer, outputs, queue and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
            active_ch <= '0;
            ptr_q     <= CH_W'(N_CH - 1);
            overflow  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            led       <= led_d;
            busy      <= busy_d;
            active_ch <= active_d;
            overflow  <= ovf_d;
            if (grant_en) begin
                ptr_q <= arb_idx;
            end
            for (int i = 0; i < N_CH; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pulse_led_scheduler.sv
// Directed bench for pulse_led_scheduler with short delay/on windows.
module tb_pulse_led_scheduler;

    localparam int D = 4;
    localparam int O = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic       led;
    logic       active_ch;
    logic       busy;
    logic [1:0] overflow;

    int total = 0;
    int bad   = 0;

    logic [1:0] reqv [64];
    int         gcyc [8];
    int         gch  [8];
    int         ng;
    int         ovf_cycle;
    logic [1:0] ovf_mask;

    pulse_led_scheduler #(
        .N_CH         (2),
        .PEND_W       (2),
        .CNT_W        (32),
        .DELAY_CYCLES (D),
        .ON_CYCLES    (O)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .led       (led),
        .active_ch (active_ch),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 64; i++) reqv[i] = 2'b00;
        ng        = 0;
        ovf_cycle = 1000;
        ovf_mask  = 2'b00;
    endtask

    task automatic add_grant(input int c, input int ch);
        gcyc[ng] = c;
        gch[ng]  = ch;
        ng++;
    endtask

    task automatic do_reset(input string name);
        req = 2'b00;
        rst = 1'b1;
        tick();
        tick();
        chk({name, "_rst_led"},  32'(led),       32'd0);
        chk({name, "_rst_busy"}, 32'(busy),      32'd0);
        chk({name, "_rst_ch"},   32'(active_ch), 32'd0);
        chk({name, "_rst_ovf"},  32'(overflow),  32'd0);
        rst = 1'b0;
        clear_plan();
    endtask

    // Applies reqv[k] at edge Ek and checks outputs after each edge against
    // the expected grant schedule: busy g..g+D+O-1, led g+D..g+D+O-1.
    task automatic run(input string name, input int last);
        logic       eled, ebusy, ech;
        logic [1:0] eovf;
        for (int k = 0; k <= last; k++) begin
            req = reqv[k];
            tick();
            req   = 2'b00;
            eled  = 1'b0;
            ebusy = 1'b0;
            ech   = 1'b0;
            for (int j = 0; j < ng; j++) begin
                if (gcyc[j] <= k) begin
                    ech = gch[j][0];
                    if (k < gcyc[j] + D + O) ebusy = 1'b1;
                    if (k >= gcyc[j] + D && k < gcyc[j] + D + O) eled = 1'b1;
                end
            end
            eovf = (k >= ovf_cycle) ? ovf_mask : 2'b00;
            chk($sformatf("%s_led@E%0d", name, k),  32'(led),       32'(eled));
            chk($sformatf("%s_busy@E%0d", name, k), 32'(busy),      32'(ebusy));
            chk($sformatf("%s_ch@E%0d", name, k),   32'(active_ch), 32'(ech));
            chk($sformatf("%s_ovf@E%0d", name, k),  32'(overflow),  32'(eovf));
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00;

        // Single event on ch0.
        do_reset("s1");
        reqv[0] = 2'b01;
        add_grant(1, 0);
        run("s1", 12);

        // Two queued events on ch0.
        do_reset("s2");
        reqv[0] = 2'b01;
        reqv[2] = 2'b01;
        add_grant(1, 0);
        add_grant(9, 0);
        run("s2", 22);

        // Round-robin from reset pointer, then with pointer left at ch0.
        do_reset("s3");
        reqv[0]  = 2'b11;
        reqv[17] = 2'b01;
        reqv[25] = 2'b11;
        add_grant(1, 0);
        add_grant(9, 1);
        add_grant(18, 0);
        add_grant(26, 1);
        add_grant(34, 0);
        run("s3", 44);

        // Saturation of ch1 while ch0 is in its delay window.
        do_reset("s4");
        reqv[0] = 2'b01;
        for (int k = 1; k <= 5; k++) reqv[k] = 2'b10;
        add_grant(1, 0);
        add_grant(9, 1);
        add_grant(17, 1);
        add_grant(25, 1);
        ovf_cycle = 4;
        ovf_mask  = 2'b10;
        run("s4", 36);

        // Grant and new strobe on the same edge.
        do_reset("s5");
        reqv[0] = 2'b01;
        reqv[1] = 2'b01;
        add_grant(1, 0);
        add_grant(9, 0);
        run("s5", 22);

        // Reset while the LED is on discards everything queued.
        do_reset("s6");
        reqv[0] = 2'b01;
        for (int k = 1; k <= 5; k++) reqv[k] = 2'b10;
        add_grant(1, 0);
        ovf_cycle = 4;
        ovf_mask  = 2'b10;
        run("s6", 5);
        rst = 1'b1;
        tick();
        chk("s6_abort_led",  32'(led),       32'd0);
        chk("s6_abort_busy", 32'(busy),      32'd0);
        chk("s6_abort_ovf",  32'(overflow),  32'd0);
        chk("s6_abort_ch",   32'(active_ch), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("s6_quiet_led@%0d", k),  32'(led),  32'd0);
            chk($sformatf("s6_quiet_busy@%0d", k), 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_led_scheduler.md
Name: pulse_led_scheduler

Overview:
- Shares one indicator LED between N_CH pulse-capture channels.
- Each channel delivers single-cycle, already-synchronized event strobes (posedge-detector outputs). The block queues them as per-channel pending counts.
- It serves queued events one at a time in round-robin order. Each event produces a delay window of DELAY_CYCLES, then an LED-on window of ON_CYCLES.
- Sits between the per-input posedge detectors and the board LED pin, in the clk_wiz output clock domain.

Parameters:
- N_CH, 2, number of requesting channels (≥2).
- CH_W, $clog2(N_CH), channel index width (derived).
- PEND_W, 8, width of each per-channel pending counter.
- CNT_W, 32, width of the delay/on timer.
- DELAY_CYCLES, 100_000_000, cycles from grant to LED rise (≥1, < 2^CNT_W).
- ON_CYCLES, 100_000_000, cycles the LED stays high per event (≥1, < 2^CNT_W).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- req  in  N_CH  per-channel event strobe; each high cycle is one event.
- led  out  1  LED drive, registered.
- active_ch  out  CH_W  channel currently being served; holds the last value when idle.
- busy  out  1  high in DELAY or ON state.
- overflow  out  N_CH  sticky per-channel flag; set when an event is dropped at saturation.

Behaviour:
- Reset (synchronous, active-high):
  - Dominates all other inputs.
  - At the reset edge: state=IDLE, led=0, busy=0, active_ch=0, all pending=0, overflow=0, timer=0.
  - Round-robin pointer is set to N_CH-1, so ch0 has first priority.
  - Reset mid-DELAY or mid-ON aborts the event and clears led at that same edge.
- Pending counters, per channel, each edge:
  - +1 if req[i] is high.
  - -1 if channel i is granted this edge.
  - Unchanged if both happen at once.
  - Saturate at 2^PEND_W-1. A req arriving while saturated (and not granted) is dropped and sets overflow[i]. overflow clears only on rst.
- Arbiter:
  - Combinational round-robin over (pending[i]!=0).
  - Search starts at pointer+1 and wraps modulo N_CH.
  - On grant, pointer becomes the granted channel.
- FSM states: IDLE, DELAY, ON.
  - IDLE: if any pending!=0, grant. At that edge: state→DELAY, timer=0, active_ch=granted index, busy=1. Otherwise stay in IDLE.
  - DELAY: timer increments each edge. At the edge where timer==DELAY_CYCLES-1: state→ON, timer=0, led=1.
  - ON: timer increments each edge. At the edge where timer==ON_CYCLES-1: state→IDLE, led=0, busy=0.
  - No grants are made in DELAY or ON. Requests keep accumulating in those states.
- Timing:
  - req sampled at edge E0 → pending visible after E0.
  - Grant at E0+1.
  - led rises at E0+1+DELAY_CYCLES.
  - led is high for exactly ON_CYCLES cycles.
  - Back-to-back events: at least one IDLE cycle, so the next rise comes DELAY_CYCLES+1 cycles after the fall.
- req while IDLE with all pending=0: the grant happens on the following edge, never the same edge.
- Width rules: all timer compares are CNT_W unsigned. Pending arithmetic is PEND_W unsigned, with no wrap-around.

Decomposition:
- Package pulse_sched_pkg:
  - state_t enum {IDLE, DELAY, ON}.
  - Default constants DELAY_1S=100_000_000 and ON_1S=100_000_000.
- One sub-module, rr_arbiter (param N), which is natural to split out:
  - Inputs: request vector, pointer.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational.
- Pending counters, timer and FSM stay in pulse_sched_pkg's top module pulse_led_scheduler.

Test Plan:
All scenarios use DELAY_CYCLES=4, ON_CYCLES=3, PEND_W=2, N_CH=2.
1. Single event: req[0] pulse at E0 → active_ch=0 and busy=1 at E1; led rises at E5, falls at E8; busy=0 at E8.
2. Queued on one channel: req[0] at E0 and E2 → first led pulse E5–E8; second grant E9, led E13–E16; pending[0] returns to 0.
3. Round-robin: req=2'b11 at E0 → ch0 served first (led E5–E8), ch1 granted at E9 (active_ch=1, led E13–E16). Repeat with pointer=0 → ch1 served first.
4. Saturation: 5 req[1] strobes during ch0's DELAY → pending[1]=3, overflow[1]=1 after the 4th strobe; exactly 3 ch1 LED pulses follow; overflow[0]=0.
5. Simultaneous grant and req: req[0] held high at E0 and E1 → E1 is both grant and increment, so pending[0]=1 after E1; exactly 2 LED pulses total.
6. Reset mid-ON: assert rst at E6 → led=0, busy=0, pending=0, overflow=0 at E6; with no further req, led stays 0 for 20 cycles.
